// File: rtl/strike_emitter_pkg.sv
// strike_emitter_pkg: shared state encoding and default timing for the strike emitter
package strike_emitter_pkg;
  typedef enum logic [1:0] {IDLE, FLAG, GAP, DONE} state_t;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_CYC_PER_STRIKE = 4;
  localparam int DEF_GAP_CYCLES = 1;
  function automatic int phase_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/strike_emitter_if.sv
// strike_emitter_if: request/strike bus between a controller and the strike emitter
interface strike_emitter_if import strike_emitter_pkg::*; #(parameter int CNT_W = DEF_CNT_W);
  logic start;
  logic [CNT_W-1:0] target_count;
  logic abort;
  logic strike_flag;
  logic busy;
  logic done;
  logic [CNT_W-1:0] emitted_count;
  modport master(output start, target_count, abort, input strike_flag, busy, done, emitted_count);
  modport slave(input start, target_count, abort, output strike_flag, busy, done, emitted_count);
endinterface

// File: rtl/strike_emitter_phase_ctr.sv
// strike_emitter_phase_ctr: modulo-N counter held at zero while disabled, flags its last phase
module strike_emitter_phase_ctr import strike_emitter_pkg::*; #(
  parameter int N = DEF_CYC_PER_STRIKE
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic last
);
  localparam int W = phase_w(N);
  logic [W-1:0] phase;
  assign last = phase == W'(N - 1);
  always_ff @(posedge clk)
    if (rst || !en) phase <= '0;
    else phase <= last ? '0 : phase + W'(1);
endmodule

// File: rtl/strike_emitter.sv
// strike_emitter: emits a programmed number of fixed-length strikes on strike_flag
module strike_emitter import strike_emitter_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int CYC_PER_STRIKE = DEF_CYC_PER_STRIKE,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input logic clk,
  input logic rst,
  strike_emitter_if.slave bus
);
  state_t state, nxt;
  logic [CNT_W-1:0] target, emitted;
  logic abort_seen, flag_q, busy_q, done_q;
  logic f_last, g_last, accept, ab, strike;
  strike_emitter_phase_ctr #(.N(CYC_PER_STRIKE)) u_flag (
    .clk(clk), .rst(rst), .en(state == FLAG), .last(f_last)
  );
  if (GAP_CYCLES > 0) begin : g_gap
    strike_emitter_phase_ctr #(.N(GAP_CYCLES)) u_gap (
      .clk(clk), .rst(rst), .en(state == GAP), .last(g_last)
    );
  end else begin : g_nogap
    assign g_last = 1'b1;
  end
  assign accept = (state == IDLE || state == DONE) && bus.start;
  assign ab = abort_seen || bus.abort;
  // a strike begins whenever the next cycle is a fresh phase-0 flag cycle
  assign strike = nxt == FLAG && (state != FLAG || f_last);
  always_comb begin
    nxt = state;
    if (state == IDLE || state == DONE)
      nxt = accept ? (bus.target_count != '0 ? FLAG : DONE) : IDLE;
    else if (state == FLAG)
      nxt = !f_last ? FLAG : (emitted == target || ab) ? DONE : (GAP_CYCLES > 0) ? GAP : FLAG;
    else
      nxt = ab ? DONE : g_last ? FLAG : GAP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      target <= '0;
      emitted <= '0;
      abort_seen <= 1'b0;
      flag_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= nxt;
      flag_q <= nxt == FLAG;
      busy_q <= nxt == FLAG || nxt == GAP;
      done_q <= nxt == DONE;
      abort_seen <= (state == FLAG || state == GAP) && ab;
      emitted <= accept ? CNT_W'(strike) : emitted + CNT_W'(strike);
      if (accept) target <= bus.target_count;
    end
  end
  assign bus.strike_flag = flag_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.emitted_count = emitted;
endmodule

// File: tb/tb_strike_emitter.sv
// tb_strike_emitter: directed bench with a request-level model and a downstream strike counter
module tb_strike_emitter;
  localparam int C = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int gap [2] = '{1, 0};
  bit act [2];
  bit abd [2];
  int k [2];
  int n [2];
  bit e_flag [2];
  bit e_busy [2];
  bit e_done [2];
  int e_emit [2];
  logic [3:0] cnt [2];
  int cph [2];
  always #5 clk = ~clk;

  strike_emitter_if #(.CNT_W(4)) b0 ();
  strike_emitter_if #(.CNT_W(4)) b1 ();
  strike_emitter #(.CNT_W(4), .CYC_PER_STRIKE(4), .GAP_CYCLES(1)) d0 (.clk(clk), .rst(rst), .bus(b0.slave));
  strike_emitter #(.CNT_W(4), .CYC_PER_STRIKE(4), .GAP_CYCLES(0)) d1 (.clk(clk), .rst(rst), .bus(b1.slave));

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  // request-level model: position k within the request decides every output
  task automatic step(input int i, input logic r, input logic s, input logic [3:0] t, input logic a);
    int p;
    int w;
    p = C + gap[i];
    if (r) begin
      act[i] = 0; abd[i] = 0; e_flag[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_emit[i] = 0;
      return;
    end
    e_done[i] = 0;
    if (!act[i]) begin
      if (s) begin
        e_emit[i] = 0;
        abd[i] = 0;
        if (t == 0) e_done[i] = 1;
        else begin act[i] = 1; k[i] = 0; n[i] = int'(t); end
      end
    end else begin
      abd[i] = abd[i] | a;
      w = k[i] % p;
      if ((w == C - 1 && (k[i] / p + 1 == n[i] || abd[i])) || (w >= C && abd[i])) begin
        act[i] = 0;
        e_done[i] = 1;
      end else k[i]++;
    end
    e_flag[i] = act[i] && (k[i] % p < C);
    e_busy[i] = act[i];
    if (act[i]) e_emit[i] = (k[i] / p + 1) % 16;
  endtask

  task automatic count(input int i, input logic f);
    if (rst) begin cnt[i] = 0; cph[i] = 0; end
    else if (f) begin
      if (cph[i] == 0) cnt[i] = cnt[i] + 4'd1;
      cph[i] = (cph[i] + 1) % C;
    end
  endtask

  always @(posedge clk) begin
    count(0, b0.strike_flag);
    count(1, b1.strike_flag);
    step(0, rst, b0.start, b0.target_count, b0.abort);
    step(1, rst, b1.start, b1.target_count, b1.abort);
  end

  always @(negedge clk) begin
    check("flag0", 32'(b0.strike_flag), 32'(e_flag[0]));
    check("busy0", 32'(b0.busy), 32'(e_busy[0]));
    check("done0", 32'(b0.done), 32'(e_done[0]));
    check("emit0", 32'(b0.emitted_count), 32'(e_emit[0]));
    check("flag1", 32'(b1.strike_flag), 32'(e_flag[1]));
    check("busy1", 32'(b1.busy), 32'(e_busy[1]));
    check("done1", 32'(b1.done), 32'(e_done[1]));
    check("emit1", 32'(b1.emitted_count), 32'(e_emit[1]));
  end

  task automatic tick(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic start0(input logic [3:0] t);
    b0.target_count = t;
    b0.start = 1'b1;
    tick(1);
    b0.start = 1'b0;
  endtask

  task automatic start1(input logic [3:0] t);
    b1.target_count = t;
    b1.start = 1'b1;
    tick(1);
    b1.start = 1'b0;
  endtask

  initial begin
    logic [13:0] pat;
    int ones;
    b0.start = 0; b0.abort = 0; b0.target_count = 0;
    b1.start = 0; b1.abort = 0; b1.target_count = 0;
    tick(3);
    check("rst_flag", 32'(b0.strike_flag), 0);
    check("rst_busy", 32'(b0.busy), 0);
    check("rst_done", 32'(b0.done), 0);
    check("rst_emit", 32'(b0.emitted_count), 0);
    rst = 1'b0;
    tick(1);
    // three strikes with one-cycle gaps
    start0(3);
    pat = '0;
    for (int i = 0; i < 14; i++) begin
      pat = {pat[12:0], b0.strike_flag};
      tick(1);
    end
    check("t1_pattern", 32'(pat), 32'(14'b11110111101111));
    check("t1_done", 32'(b0.done), 1);
    check("t1_emit", 32'(b0.emitted_count), 3);
    check("t1_cnt", 32'(cnt[0]), 3);
    // zero target finishes at once
    do_reset();
    start0(0);
    check("t2_done", 32'(b0.done), 1);
    check("t2_flag", 32'(b0.strike_flag), 0);
    tick(1);
    check("t2_done_end", 32'(b0.done), 0);
    check("t2_cnt", 32'(cnt[0]), 0);
    // abort during strike 2 lets it finish
    do_reset();
    start0(5);
    tick(6);
    b0.abort = 1'b1;
    tick(1);
    b0.abort = 1'b0;
    tick(2);
    check("t3_done", 32'(b0.done), 1);
    check("t3_emit", 32'(b0.emitted_count), 2);
    check("t3_cnt", 32'(cnt[0]), 2);
    tick(3);
    check("t3_idle", 32'(b0.strike_flag), 0);
    // back-to-back strikes, then counter wrap
    start1(15);
    ones = 0;
    for (int i = 0; i < 60; i++) begin
      ones += int'(b1.strike_flag);
      tick(1);
    end
    check("t4_ones", 32'(ones), 60);
    check("t4_done", 32'(b1.done), 1);
    check("t4_cnt", 32'(cnt[1]), 15);
    check("t4_emit", 32'(b1.emitted_count), 15);
    tick(1);
    start1(1);
    tick(4);
    check("t4_wrap_done", 32'(b1.done), 1);
    check("t4_wrap_cnt", 32'(cnt[1]), 0);
    check("t4_wrap_emit", 32'(b1.emitted_count), 1);
    // start while busy is ignored; start in DONE is accepted
    do_reset();
    start0(2);
    tick(2);
    start0(7);
    tick(6);
    check("t5_done", 32'(b0.done), 1);
    check("t5_emit", 32'(b0.emitted_count), 2);
    check("t5_cnt", 32'(cnt[0]), 2);
    start0(1);
    check("t5_restart_flag", 32'(b0.strike_flag), 1);
    check("t5_restart_busy", 32'(b0.busy), 1);
    tick(4);
    check("t5_restart_done", 32'(b0.done), 1);
    check("t5_restart_cnt", 32'(cnt[0]), 3);
    // reset mid-strike
    tick(1);
    start0(3);
    tick(1);
    rst = 1'b1;
    tick(1);
    check("t6_flag", 32'(b0.strike_flag), 0);
    check("t6_busy", 32'(b0.busy), 0);
    check("t6_done", 32'(b0.done), 0);
    check("t6_emit", 32'(b0.emitted_count), 0);
    rst = 1'b0;
    tick(1);
    start0(1);
    tick(4);
    check("t6_run_done", 32'(b0.done), 1);
    check("t6_run_cnt", 32'(cnt[0]), 1);
    // abort inside a gap, and start+abort together in IDLE
    do_reset();
    start0(4);
    tick(4);
    check("t7_gap_flag", 32'(b0.strike_flag), 0);
    b0.abort = 1'b1;
    tick(1);
    b0.abort = 1'b0;
    check("t7_gap_done", 32'(b0.done), 1);
    check("t7_gap_emit", 32'(b0.emitted_count), 1);
    check("t7_gap_cnt", 32'(cnt[0]), 1);
    tick(1);
    b0.target_count = 2;
    b0.start = 1'b1;
    b0.abort = 1'b1;
    tick(1);
    b0.start = 1'b0;
    b0.abort = 1'b0;
    tick(9);
    check("t7_sa_done", 32'(b0.done), 1);
    check("t7_sa_emit", 32'(b0.emitted_count), 2);
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
